// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, address-step constant and cache geometry
// helpers for the instruction fetch unit and its direct-mapped I-cache.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,  // look up the cache, push on hit, request on miss
    ST_MISS  = 2'd1,  // demand request outstanding, push the returned word
    ST_DRAIN = 2'd2   // request made stale by a redirect, fill only
  } fetch_state_e;

  // Byte distance between consecutive instructions.
  localparam int ADDR_DISTANCE = 4;

  // Word-aligned instructions: the two low PC bits never address the cache.
  localparam int BYTE_OFS_W = 2;

  // Number of PC bits used to select a cache entry.
  function automatic int index_width(input int depth);
    return $clog2(depth);
  endfunction

  // Number of PC bits stored as tag above the index field.
  function automatic int tag_width(input int addr_w, input int depth);
    return addr_w - $clog2(depth) - BYTE_OFS_W;
  endfunction

endpackage

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache storage. One combinational
// lookup port for the fetch PC, one fill port, and a whole-cache flush that
// wins over a fill on the same edge. With PREFETCH_EN defined a second
// lookup port (probe) checks whether the next sequential line is present.
module icache_dm
  import fetch_pkg::*;
#(
  parameter int ADDR_W   = 32,
  parameter int INST_W   = 32,
  parameter int IC_DEPTH = 256
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              en_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] lookup_pc_i,
  output logic              lookup_hit_o,
  output logic [INST_W-1:0] lookup_data_o,
`ifdef PREFETCH_EN
  input  logic [ADDR_W-1:0] probe_pc_i,
  output logic              probe_hit_o,
`endif
  input  logic              fill_i,
  input  logic [ADDR_W-1:0] fill_pc_i,
  input  logic [INST_W-1:0] fill_data_i
);

  localparam int IDX_W = index_width(IC_DEPTH);
  localparam int TAG_W = tag_width(ADDR_W, IC_DEPTH);

  logic [INST_W-1:0]   data_q [IC_DEPTH];
  logic [TAG_W-1:0]    tag_q  [IC_DEPTH];
  logic [IC_DEPTH-1:0] valid_q;
  logic [IC_DEPTH-1:0] valid_d;

  function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] pc);
    return pc[IDX_W+1:BYTE_OFS_W];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input logic [ADDR_W-1:0] pc);
    return pc[ADDR_W-1:IDX_W+BYTE_OFS_W];
  endfunction

  logic [IDX_W-1:0] lookup_idx;
  logic [IDX_W-1:0] fill_idx;

  assign lookup_idx    = idx_of(lookup_pc_i);
  assign fill_idx      = idx_of(fill_pc_i);
  assign lookup_hit_o  = valid_q[lookup_idx] && (tag_q[lookup_idx] == tag_of(lookup_pc_i));
  assign lookup_data_o = data_q[lookup_idx];

`ifdef PREFETCH_EN
  logic [IDX_W-1:0] probe_idx;
  assign probe_idx   = idx_of(probe_pc_i);
  assign probe_hit_o = valid_q[probe_idx] && (tag_q[probe_idx] == tag_of(probe_pc_i));

  // Byte-offset bits are never looked at.
  logic unused_ofs;
  assign unused_ofs = ^{lookup_pc_i[1:0], fill_pc_i[1:0], probe_pc_i[1:0]};
`else
  // Byte-offset bits are never looked at.
  logic unused_ofs;
  assign unused_ofs = ^{lookup_pc_i[1:0], fill_pc_i[1:0]};
`endif

  // Next valid vector: a fill sets its entry, a flush then clears everything.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    valid_d = valid_q;
    if (fill_i) valid_d[fill_idx] = 1'b1;
    if (flush_i) valid_d = '0;
  end

  // Valid bits: the only storage that needs a reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_n_i) begin
      valid_q <= '0;
    end else if (en_i) begin
      valid_q <= valid_d;
    end
  end

  // Data and tag arrays written on fill.
  always_ff @(posedge clk_i) begin
    // NOTE: the arrays are deliberately not reset; the valid bits qualify them, so they can map onto plain RAM.
    if (en_i && fill_i) begin
      data_q[fill_idx] <= fill_data_i;
      tag_q[fill_idx]  <= tag_of(fill_pc_i);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front end. Looks up the PC in a
// direct-mapped I-cache, pushes hits into the instruction queue one per
// cycle, and fetches misses from memory with a single outstanding request.
// Redirects override every fetch action; a redirect during a miss turns the
// pending request into a fill-only drain.
// Optional build macro: PREFETCH_EN -- after a demand fill, prefetch the
// next sequential line (fill only) if it is not already cached.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                IC_DEPTH = 256,   // power of two, >= 2
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              rdy_in,
  input  logic              iq_full_in,
  output logic              iq_write_out,
  output logic [INST_W-1:0] iq_inst_out,
  output logic [ADDR_W-1:0] iq_pc_out,
  output logic              mem_req_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  input  logic              mem_ack_in,
  input  logic [INST_W-1:0] mem_data_in,
  input  logic              redirect_in,
  input  logic [ADDR_W-1:0] redirect_pc_in,
  input  logic              flush_in
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              iq_write_q, iq_write_d;
  logic [INST_W-1:0] iq_inst_q, iq_inst_d;
  logic [ADDR_W-1:0] iq_pc_q, iq_pc_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic              hit;
  logic [INST_W-1:0] hit_data;
  logic              fill;
  logic              demand_ok;   // memory port free for a demand miss
  logic [ADDR_W-1:0] pc_inc;

  assign pc_inc = pc_q + ADDR_W'(ADDR_DISTANCE);

`ifdef PREFETCH_EN
  logic              pf_pend_q, pf_pend_d;   // prefetch decided, not yet issued
  logic              pf_busy_q, pf_busy_d;   // prefetch request outstanding
  logic [ADDR_W-1:0] pf_addr_q, pf_addr_d;
  logic [ADDR_W-1:0] pf_probe_pc;
  logic              pf_probe_hit;

  // The line after the one being filled; it never aliases the filled entry.
  assign pf_probe_pc = mem_addr_q + ADDR_W'(ADDR_DISTANCE);
  assign demand_ok   = !pf_pend_q && !pf_busy_q;
`else
  assign demand_ok   = 1'b1;
`endif

  icache_dm #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .IC_DEPTH(IC_DEPTH)
  ) u_icache (
    .clk_i        (clk_in),
    .rst_n_i      (rst_n_in),
    .en_i         (rdy_in),
    .flush_i      (flush_in),
    .lookup_pc_i  (pc_q),
    .lookup_hit_o (hit),
    .lookup_data_o(hit_data),
`ifdef PREFETCH_EN
    .probe_pc_i   (pf_probe_pc),
    .probe_hit_o  (pf_probe_hit),
`endif
    .fill_i       (fill),
    .fill_pc_i    (mem_addr_q),
    .fill_data_i  (mem_data_in)
  );

  // Next-state, PC, queue push and memory request decisions.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    iq_write_d = 1'b0;
    iq_inst_d  = iq_inst_q;
    iq_pc_d    = iq_pc_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fill       = 1'b0;
`ifdef PREFETCH_EN
    pf_pend_d  = pf_pend_q;
    pf_busy_d  = pf_busy_q;
    pf_addr_d  = pf_addr_q;
`endif

    unique case (state_q)
      ST_FETCH: begin
`ifdef PREFETCH_EN
        // Prefetch traffic runs alongside hit service; it never touches the PC,
        // so a redirect while it is in flight simply leaves it as a fill.
        if (pf_pend_q) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pf_addr_q;
          pf_pend_d  = 1'b0;
          pf_busy_d  = 1'b1;
        end
        if (pf_busy_q && mem_ack_in) begin
          fill      = 1'b1;
          mem_req_d = 1'b0;
          pf_busy_d = 1'b0;
        end
`endif
        if (redirect_in) begin
          pc_d = redirect_pc_in;
        end else if (hit) begin
          if (!iq_full_in) begin
            iq_write_d = 1'b1;
            iq_inst_d  = hit_data;
            iq_pc_d    = pc_q;
            pc_d       = pc_inc;
          end
        end else if (demand_ok) begin
          mem_req_d  = 1'b1;
          mem_addr_d = pc_q;
          state_d    = ST_MISS;
        end
      end

      ST_MISS: begin
        if (mem_ack_in) begin
          fill      = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_FETCH;
          if (redirect_in) begin
            pc_d = redirect_pc_in;
          end else begin
            // The PC is held during a miss, so it equals the returned address.
            if (!iq_full_in) begin
              iq_write_d = 1'b1;
              iq_inst_d  = mem_data_in;
              iq_pc_d    = pc_q;
              pc_d       = pc_inc;
            end
`ifdef PREFETCH_EN
            if (!pf_probe_hit) begin
              pf_pend_d = 1'b1;
              pf_addr_d = pf_probe_pc;
            end
`endif
          end
        end else if (redirect_in) begin
          pc_d    = redirect_pc_in;
          state_d = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (redirect_in) pc_d = redirect_pc_in;
        if (mem_ack_in) begin
          fill      = 1'b1;
          mem_req_d = 1'b0;
          state_d   = ST_FETCH;
        end
      end

      default: begin
        state_d   = ST_FETCH;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // Fetch state, PC and registered outputs; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= ST_FETCH;
      pc_q       <= RESET_PC;
      iq_write_q <= 1'b0;
      iq_inst_q  <= '0;
      iq_pc_q    <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      iq_write_q <= iq_write_d;
      iq_inst_q  <= iq_inst_d;
      iq_pc_q    <= iq_pc_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

`ifdef PREFETCH_EN
  // Prefetch bookkeeping; a reset abandons any prefetch in flight.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pf_pend_q <= 1'b0;
      pf_busy_q <= 1'b0;
      pf_addr_q <= '0;
    end else if (rdy_in) begin
      pf_pend_q <= pf_pend_d;
      pf_busy_q <= pf_busy_d;
      pf_addr_q <= pf_addr_d;
    end
  end
`endif

  assign iq_write_out = iq_write_q;
  assign iq_inst_out  = iq_inst_q;
  assign iq_pc_out    = iq_pc_q;
  assign mem_req_out  = mem_req_q;
  assign mem_addr_out = mem_addr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios for the fetch unit followed by a
// randomized run checked against a transaction-level reference: the pushed
// PC stream must follow reset/redirect targets in steps of 4, every pushed
// word must equal the memory image, and no request may be made for a line a
// simple cache model says is present.
module tb_fetch_unit;

  localparam int                ADDR_W   = 32;
  localparam int                INST_W   = 32;
  localparam int                IC_DEPTH = 64;
  localparam logic [ADDR_W-1:0] RESET_PC = '0;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic              rdy_in;
  logic              iq_full_in;
  logic              iq_write_out;
  logic [INST_W-1:0] iq_inst_out;
  logic [ADDR_W-1:0] iq_pc_out;
  logic              mem_req_out;
  logic [ADDR_W-1:0] mem_addr_out;
  logic              mem_ack_in;
  logic [INST_W-1:0] mem_data_in;
  logic              redirect_in;
  logic [ADDR_W-1:0] redirect_pc_in;
  logic              flush_in;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .ADDR_W  (ADDR_W),
    .INST_W  (INST_W),
    .IC_DEPTH(IC_DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rdy_in        (rdy_in),
    .iq_full_in    (iq_full_in),
    .iq_write_out  (iq_write_out),
    .iq_inst_out   (iq_inst_out),
    .iq_pc_out     (iq_pc_out),
    .mem_req_out   (mem_req_out),
    .mem_addr_out  (mem_addr_out),
    .mem_ack_in    (mem_ack_in),
    .mem_data_in   (mem_data_in),
    .redirect_in   (redirect_in),
    .redirect_pc_in(redirect_pc_in),
    .flush_in      (flush_in)
  );

  always #5 clk_in = ~clk_in;

  // Memory image: address 0 holds 0x00000013, every word is unique.
  function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Reference cache contents: which address each entry currently holds.
  bit                mc_val  [IC_DEPTH];
  logic [ADDR_W-1:0] mc_addr [IC_DEPTH];

  function automatic int mc_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] t;
    t = (a / 4) % IC_DEPTH;
    return int'(t);
  endfunction

  function automatic bit mc_hit(input logic [ADDR_W-1:0] a);
    return mc_val[mc_idx(a)] && (mc_addr[mc_idx(a)] == a);
  endfunction

  task automatic mc_fill(input logic [ADDR_W-1:0] a);
    mc_val[mc_idx(a)]  = 1'b1;
    mc_addr[mc_idx(a)] = a;
  endtask

  task automatic mc_clear();
    for (int i = 0; i < IC_DEPTH; i++) mc_val[i] = 1'b0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_inputs();
    iq_full_in     = 1'b0;
    mem_ack_in     = 1'b0;
    mem_data_in    = '0;
    redirect_in    = 1'b0;
    redirect_pc_in = '0;
    flush_in       = 1'b0;
  endtask

  // Expect a pending request for addr, then answer it on the next edge.
  task automatic serve(input string tag, input logic [ADDR_W-1:0] addr);
    check({tag, "_req"}, mem_req_out, 1'b1);
    check({tag, "_addr"}, mem_addr_out, addr);
    mem_ack_in  = 1'b1;
    mem_data_in = mem_word(addr);
    tick();
    mem_ack_in  = 1'b0;
  endtask

  task automatic expect_push(input string tag, input logic [ADDR_W-1:0] pc);
    check({tag, "_wr"}, iq_write_out, 1'b1);
    check({tag, "_pc"}, iq_pc_out, pc);
    check({tag, "_inst"}, iq_inst_out, mem_word(pc));
  endtask

  // Redirect for exactly one edge.
  task automatic redirect(input logic [ADDR_W-1:0] target);
    redirect_in    = 1'b1;
    redirect_pc_in = target;
    tick();
    redirect_in    = 1'b0;
  endtask

  logic [ADDR_W-1:0] exp_pc;
  logic [ADDR_W-1:0] req_addr;
  bit                req_seen;
  bit                ack_prev;
  int                lat;
  int                pushes;

  initial begin
    rst_n_in = 1'b0;
    rdy_in   = 1'b1;
    idle_inputs();
    #12;
    check("rst_iq_write", iq_write_out, 1'b0);
    check("rst_iq_inst", iq_inst_out, '0);
    check("rst_iq_pc", iq_pc_out, '0);
    check("rst_mem_req", mem_req_out, 1'b0);
    check("rst_mem_addr", mem_addr_out, '0);
    rst_n_in = 1'b1;

`ifdef PREFETCH_EN
    // Demand miss at 0x40 followed by a prefetch of 0x44, which then hits.
    redirect(32'h40);
    check("pf_redir_noreq", mem_req_out, 1'b0);
    tick();
    serve("pf_miss40", 32'h40);
    expect_push("pf_push40", 32'h40);
    tick();
    check("pf_req44", mem_req_out, 1'b1);
    check("pf_addr44", mem_addr_out, 32'h44);
    check("pf_nopush", iq_write_out, 1'b0);
    tick();
    serve("pf_fill44", 32'h44);
    check("pf_fill_nopush", iq_write_out, 1'b0);
    check("pf_fill_reqdrop", mem_req_out, 1'b0);
    tick();
    expect_push("pf_hit44", 32'h44);
    check("pf_hit44_noreq", mem_req_out, 1'b0);
`else
    // Cold miss at the reset PC; the word is pushed on the ack edge.
    tick();
    check("cold_req", mem_req_out, 1'b1);
    check("cold_addr", mem_addr_out, 32'h0);
    check("cold_nopush", iq_write_out, 1'b0);
    tick();
    serve("cold_hold", 32'h0);
    expect_push("cold_push", 32'h0);
    check("cold_reqdrop", mem_req_out, 1'b0);
    tick();
    check("next_req4", mem_req_out, 1'b1);
    check("next_addr4", mem_addr_out, 32'h4);

    // Finish the first pass over 0x0..0xC.
    serve("fill4", 32'h4);
    expect_push("push4", 32'h4);
    tick();
    serve("fill8", 32'h8);
    expect_push("push8", 32'h8);
    tick();
    serve("fillc", 32'hC);
    expect_push("pushc", 32'hC);

    // Second pass: four back-to-back hits with no memory traffic.
    redirect(32'h0);
    check("loop_redir_nopush", iq_write_out, 1'b0);
    check("loop_redir_noreq", mem_req_out, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_push("loop_hit", ADDR_W'(4 * i));
      check("loop_noreq", mem_req_out, 1'b0);
    end

    // Queue full for three cycles during hits: nothing moves, then resume.
    redirect(32'h0);
    iq_full_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("full_nopush", iq_write_out, 1'b0);
      check("full_noreq", mem_req_out, 1'b0);
    end
    iq_full_in = 1'b0;
    tick();
    expect_push("full_resume", 32'h0);

    // Flush while hitting 0x4 (lookup precedes the clear), then miss on 0x8.
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    expect_push("flush_hit4", 32'h4);
    tick();
    check("miss8_req", mem_req_out, 1'b1);
    check("miss8_addr", mem_addr_out, 32'h8);

    // Redirect to 0x100 while the 0x8 miss is pending: fill only, no push.
    redirect(32'h100);
    check("drain_nopush", iq_write_out, 1'b0);
    check("drain_req_hold", mem_req_out, 1'b1);
    check("drain_addr_hold", mem_addr_out, 32'h8);
    tick();
    serve("drain8", 32'h8);
    check("drain_ack_nopush", iq_write_out, 1'b0);
    check("drain_ack_reqdrop", mem_req_out, 1'b0);
    tick();
    serve("after_drain", 32'h100);
    expect_push("push100", 32'h100);

    // The drained line 0x8 was filled and now hits.
    redirect(32'h8);
    check("redir8_nopush", iq_write_out, 1'b0);
    tick();
    expect_push("drained_hit8", 32'h8);
    check("drained_hit8_noreq", mem_req_out, 1'b0);

    // Flush on the same edge as the 0x20 fill: pushed, but left invalid.
    redirect(32'h20);
    check("redir20_noreq", mem_req_out, 1'b0);
    tick();
    flush_in = 1'b1;
    serve("fill20", 32'h20);
    flush_in = 1'b0;
    expect_push("flushfill_push20", 32'h20);
    redirect(32'h20);
    tick();
    check("refetch20_req", mem_req_out, 1'b1);
    check("refetch20_addr", mem_addr_out, 32'h20);
    check("refetch20_nopush", iq_write_out, 1'b0);
    serve("refill20", 32'h20);
    expect_push("refill_push20", 32'h20);

    // rdy_in low freezes outputs and state; the pending miss on 0x24 waits.
    rdy_in = 1'b0;
    tick();
    tick();
    check("frz_wr", iq_write_out, 1'b1);
    check("frz_pc", iq_pc_out, 32'h20);
    check("frz_noreq", mem_req_out, 1'b0);
    rdy_in = 1'b1;
    tick();
    check("unfrz_req", mem_req_out, 1'b1);
    check("unfrz_addr", mem_addr_out, 32'h24);
    check("unfrz_nopush", iq_write_out, 1'b0);

    // Asynchronous reset in the middle of the miss.
    #2;
    rst_n_in = 1'b0;
    #1;
    check("arst_req", mem_req_out, 1'b0);
    check("arst_addr", mem_addr_out, '0);
    check("arst_wr", iq_write_out, 1'b0);
    check("arst_pc", iq_pc_out, '0);
    check("arst_inst", iq_inst_out, '0);
    #2;
    rst_n_in = 1'b1;
    tick();
    serve("arst_cold", RESET_PC);
    expect_push("arst_push", RESET_PC);
`endif

    // Randomized run against the reference model.
    idle_inputs();
    rst_n_in = 1'b0;
    #3;
    rst_n_in = 1'b1;
    mc_clear();
    exp_pc   = RESET_PC;
    req_seen = 1'b0;
    ack_prev = 1'b0;
    req_addr = '0;
    lat      = 0;
    pushes   = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (iq_write_out) begin
        check("rnd_push_pc", iq_pc_out, exp_pc);
        check("rnd_push_inst", iq_inst_out, mem_word(iq_pc_out));
        exp_pc = exp_pc + 4;
        pushes++;
      end
      if (ack_prev) begin
        check("rnd_req_drop", mem_req_out, 1'b0);
        req_seen = 1'b0;
      end else if (mem_req_out) begin
        if (!req_seen) begin
          check("rnd_req_uncached", mc_hit(mem_addr_out), 1'b0);
          req_seen = 1'b1;
          req_addr = mem_addr_out;
          lat      = int'($urandom_range(0, 3));
        end else begin
          check("rnd_req_stable", mem_addr_out, req_addr);
        end
      end else begin
        req_seen = 1'b0;
      end

      mem_ack_in = 1'b0;
      if (req_seen) begin
        if (lat == 0) begin
          mem_ack_in  = 1'b1;
          mem_data_in = mem_word(req_addr);
        end else begin
          lat--;
        end
      end
      iq_full_in     = ($urandom_range(0, 3) == 0);
      flush_in       = ($urandom_range(0, 49) == 0);
      redirect_in    = ($urandom_range(0, 19) == 0);
      redirect_pc_in = ADDR_W'($urandom_range(0, 127)) << 2;
      if (mem_ack_in) mc_fill(req_addr);
      if (flush_in) mc_clear();
      if (redirect_in) exp_pc = redirect_pc_in;
      ack_prev = mem_ack_in;
      tick();
    end
    check("rnd_push_count", (pushes > 200), 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and memory address width.
REQ-002 SHALL have parameter INST_W, default 32, instruction width.
REQ-003 SHALL have parameter IC_DEPTH, default 256, direct-mapped I-cache entries, power of two, minimum 2.
REQ-004 SHALL have parameter RESET_PC, default 0, fetch address after reset.
REQ-005 SHALL have port clk_in  input  1  sole clock, all state on rising edge.
REQ-006 SHALL have port rst_n_in  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port rdy_in  input  1  global enable; low freezes all state.
REQ-008 SHALL have port iq_full_in  input  1  instruction queue cannot accept.
REQ-009 SHALL have port iq_write_out  output  1  one-cycle push strobe.
REQ-010 SHALL have port iq_inst_out  output  INST_W  pushed instruction.
REQ-011 SHALL have port iq_pc_out  output  ADDR_W  PC of pushed instruction.
REQ-012 SHALL have port mem_req_out  output  1  memory read request, level.
REQ-013 SHALL have port mem_addr_out  output  ADDR_W  request address.
REQ-014 SHALL have port mem_ack_in  input  1  one-cycle response strobe.
REQ-015 SHALL have port mem_data_in  input  INST_W  response data, valid with mem_ack_in.
REQ-016 SHALL have port redirect_in  input  1  commit-stage PC redirect.
REQ-017 SHALL have port redirect_pc_in  input  ADDR_W  redirect target.
REQ-018 SHALL have port flush_in  input  1  invalidate entire I-cache.

Function
REQ-019 SHALL address cache as index = pc[log2(IC_DEPTH)+1:2], tag = pc[ADDR_W-1:log2(IC_DEPTH)+2]; PC increment 4, wraps modulo 2^ADDR_W.
REQ-020 SHALL implement states FETCH, MISS, DRAIN; all IQ outputs registered.
REQ-021 FETCH, hit, !iq_full_in: iq_write_out=1 next cycle with cached word and current PC; PC += 4 (one-cycle hit latency, one instruction per cycle sustained).
REQ-022 FETCH, miss: mem_req_out=1, mem_addr_out=PC next cycle; go MISS.
REQ-023 FETCH, hit, iq_full_in=1: no push, PC held, no request.
REQ-024 mem_req_out and mem_addr_out SHALL stay stable until the cycle mem_ack_in=1, then deassert the following cycle; at most one request outstanding.
REQ-025 MISS + mem_ack_in: fill entry (data, tag, valid); if !iq_full_in push mem_data_in same edge and PC += 4, else PC held; go FETCH.
REQ-026 redirect_in SHALL take priority over all fetch actions; pushes in that cycle suppressed; PC <= redirect_pc_in.
REQ-027 redirect_in in FETCH: next cycle fetch from redirect_pc_in (hit push at earliest the cycle after).
REQ-028 redirect_in in MISS without mem_ack_in: go DRAIN; in DRAIN on mem_ack_in fill cache, do not push, go FETCH.
REQ-029 redirect_in in MISS with mem_ack_in same cycle: fill cache, no push, go FETCH.
REQ-030 redirect_in in DRAIN: update PC only, remain DRAIN.
REQ-031 flush_in SHALL clear all valid bits next edge; flush beats a same-cycle fill (entry ends invalid); an outstanding request still completes and is pushed if not stale.
REQ-032 rdy_in=0 SHALL freeze state and outputs; memctrl is gated by the same rdy_in, so mem_ack_in is never asserted while rdy_in=0.

Reset
REQ-033 rst_n_in low SHALL immediately set state=FETCH, PC=RESET_PC, all valid bits 0, iq_write_out=0, iq_inst_out=0, iq_pc_out=0, mem_req_out=0, mem_addr_out=0; data/tag arrays not reset.
REQ-034 Reset mid-MISS SHALL abandon the request; memctrl is reset by the same signal.

Configuration
REQ-035 With PREFETCH_EN defined: after a demand fill, if PC+4 misses, issue a prefetch request for PC+4 (fill only, never pushed); hits continue to be served meanwhile; a demand miss waits for it; redirect marks it stale (fill, no effect on PC).
REQ-036 Without PREFETCH_EN: requests only on demand misses; no prefetch logic synthesised.

Structure
REQ-037 fetch_pkg SHALL hold the state enum, ADDR_DISTANCE=4 and index/tag width helper functions.
REQ-038 Storage (data, tag, valid arrays, flush, lookup) SHALL be a sub-module icache_dm.

Verification
REQ-039 Reset, cold miss at 0x0, mem ack data 0x00000013 -> push (0x0, 0x00000013) on ack edge; 0x4 requested next.
REQ-040 Loop 0x0-0xC fetched twice -> second pass four consecutive pushes, mem_req_out=0 throughout.
REQ-041 Redirect to 0x100 while miss on 0x8 pending -> ack for 0x8 fills, no push; next request is 0x100.
REQ-042 iq_full_in=1 for 3 cycles during hits -> no push, PC held; resumes same PC.
REQ-043 flush_in same cycle as ack for 0x20 -> push occurs; refetch of 0x20 misses.
REQ-044 PREFETCH_EN: miss at 0x40 -> request 0x40 then 0x44; fetch of 0x44 hits.
